// File: rtl/exe_mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// exe_mem_stage_pkg
// Shared pipeline definitions for the EXE/MEM boundary:
//   PIPE_DATA_W  default width of ALU result / store value
//   REG_IDX_W    width of a register-file index
//   CNT_W        width of the memory wait counter
//   ST_IDLE/ST_WAIT  memory-stage occupancy state encoding
// ---------------------------------------------------------------------------
package exe_mem_stage_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int REG_IDX_W   = 4;
    localparam int CNT_W       = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/mem_wait_counter.sv
// ---------------------------------------------------------------------------
// mem_wait_counter
// Tracks how many extra cycles the current memory op still occupies the
// memory stage and derives the upstream freeze and the MEM/WB mem_done.
// Ports:
//   clock, reset   single clock, synchronous active-high reset
//   load           a memory op is being captured into the stage this edge
//   out_valid      the stage currently holds a valid instruction
//   freeze         hold upstream stages (cnt != 0)
//   mem_done       stage contents are final this cycle
// ---------------------------------------------------------------------------
module mem_wait_counter
    import exe_mem_stage_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic out_valid,
    output logic freeze,
    output logic mem_done
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [0:0]       state;

    always_comb begin
        cnt_nxt = cnt;
        if (load)
            cnt_nxt = WAIT_LD;
        else if (cnt != '0)
            cnt_nxt = cnt - 1'b1;
    end

    // state mirrors cnt != 0 and updates in lockstep with it
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            state <= ST_IDLE;
        end else begin
            cnt   <= cnt_nxt;
            state <= (cnt_nxt != '0) ? ST_WAIT : ST_IDLE;
        end
    end

    assign freeze   = (cnt != '0);
    assign mem_done = out_valid & (state == ST_IDLE);

endmodule

// File: rtl/exe_mem_stage.sv
// ---------------------------------------------------------------------------
// exe_mem_stage
// EXE/MEM pipeline register with bubble insertion and a fixed-latency
// memory wait: a load/store occupies the memory stage WAIT_CYCLES+1 cycles
// while freeze holds the upstream stages.
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   flush                 turn the incoming instruction into a bubble
//   in_*                  EXE-stage valid, controls, result, store data, dest
//   out_*                 registered copies to the memory stage
//                         (out_mem_w_en only asserted in the final cycle)
//   freeze                hold PC, IF/ID and ID/EXE this cycle
//   stall_cycles          saturating count of frozen cycles (optional)
//   mem_done              MEM/WB may capture this cycle
// Optional feature: define EXE_MEM_STALL_CNT_EN to add stall_cycles.
// ---------------------------------------------------------------------------
module exe_mem_stage
    import exe_mem_stage_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = PIPE_DATA_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic                 in_wb_en,
    input  logic                 in_mem_r_en,
    input  logic                 in_mem_w_en,
    input  logic [DATA_W-1:0]    in_alu_result,
    input  logic [DATA_W-1:0]    in_st_value,
    input  logic [REG_IDX_W-1:0] in_dest,
    output logic                 out_valid,
    output logic                 out_wb_en,
    output logic                 out_mem_r_en,
    output logic                 out_mem_w_en,
    output logic [DATA_W-1:0]    out_alu_result,
    output logic [DATA_W-1:0]    out_st_value,
    output logic [REG_IDX_W-1:0] out_dest,
    output logic                 freeze,
`ifdef EXE_MEM_STALL_CNT_EN
    output logic [31:0]          stall_cycles,
`endif
    output logic                 mem_done
);

    logic take_p0;
    logic load_cnt_p0;
    logic mem_w_en_p1;

    // EXE -> MEM capture boundary
    assign take_p0     = in_valid & ~flush;
    assign load_cnt_p0 = ~freeze & take_p0 & (in_mem_r_en | in_mem_w_en);

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_wb_en      <= 1'b0;
            out_mem_r_en   <= 1'b0;
            mem_w_en_p1    <= 1'b0;
            out_alu_result <= '0;
            out_st_value   <= '0;
            out_dest       <= '0;
        end else if (!freeze) begin
            out_valid      <= take_p0;
            out_wb_en      <= in_wb_en & take_p0;
            out_mem_r_en   <= in_mem_r_en & take_p0;
            mem_w_en_p1    <= in_mem_w_en & take_p0;
            out_alu_result <= in_alu_result;
            out_st_value   <= in_st_value;
            out_dest       <= in_dest;
        end
    end

    // Store strobe is masked until the last occupancy cycle so it fires once
    assign out_mem_w_en = mem_w_en_p1 & ~freeze;

    mem_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clock     (clock),
        .reset     (reset),
        .load      (load_cnt_p0),
        .out_valid (out_valid),
        .freeze    (freeze),
        .mem_done  (mem_done)
    );

`ifdef EXE_MEM_STALL_CNT_EN
    always_ff @(posedge clock) begin
        if (reset)
            stall_cycles <= '0;
        else if (freeze && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_exe_mem_stage.sv
module tb_exe_mem_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid, in_wb_en, in_mem_r_en, in_mem_w_en;
    logic [31:0] in_alu_result, in_st_value;
    logic [3:0]  in_dest;

    logic        out_valid, out_wb_en, out_mem_r_en, out_mem_w_en;
    logic [31:0] out_alu_result, out_st_value;
    logic [3:0]  out_dest;
    logic        freeze, mem_done;

    logic        z_valid, z_wb_en, z_mem_r_en, z_mem_w_en;
    logic [31:0] z_alu_result, z_st_value;
    logic [3:0]  z_dest;
    logic        z_freeze, z_mem_done;
`ifdef EXE_MEM_STALL_CNT_EN
    logic [31:0] stall_cycles, z_stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    exe_mem_stage #(.WAIT_CYCLES(2), .DATA_W(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_wb_en(in_wb_en),
        .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
        .in_alu_result(in_alu_result), .in_st_value(in_st_value),
        .in_dest(in_dest),
        .out_valid(out_valid), .out_wb_en(out_wb_en),
        .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
        .out_alu_result(out_alu_result), .out_st_value(out_st_value),
        .out_dest(out_dest), .freeze(freeze),
`ifdef EXE_MEM_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .mem_done(mem_done)
    );

    exe_mem_stage #(.WAIT_CYCLES(0), .DATA_W(32)) dut0 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_wb_en(in_wb_en),
        .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
        .in_alu_result(in_alu_result), .in_st_value(in_st_value),
        .in_dest(in_dest),
        .out_valid(z_valid), .out_wb_en(z_wb_en),
        .out_mem_r_en(z_mem_r_en), .out_mem_w_en(z_mem_w_en),
        .out_alu_result(z_alu_result), .out_st_value(z_st_value),
        .out_dest(z_dest), .freeze(z_freeze),
`ifdef EXE_MEM_STALL_CNT_EN
        .stall_cycles(z_stall_cycles),
`endif
        .mem_done(z_mem_done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic wb, input logic r, input logic w,
                         input logic [31:0] alu, input logic [31:0] st, input logic [3:0] d);
        in_valid = v; in_wb_en = wb; in_mem_r_en = r; in_mem_w_en = w;
        in_alu_result = alu; in_st_value = st; in_dest = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_reset();
        logic [5:0] ctl;
        reset = 1'b1; flush = 1'b0; idle();
        tick();
        reset = 1'b0;
        tick();
        ctl = {out_valid, out_wb_en, out_mem_r_en, out_mem_w_en, freeze, mem_done};
        checks++;
        if (ctl !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=000000", ctl);
        end
        checks++;
        if ({out_alu_result, out_st_value, out_dest} !== 68'h0) begin
            failures++;
            $display("FAIL reset_data alu=%h st=%h dest=%h exp=0", out_alu_result, out_st_value, out_dest);
        end
`ifdef EXE_MEM_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL reset_stall got=%0d exp=0", stall_cycles);
        end
`endif
    endtask

    task automatic test_load();
        logic [2:0] exp_frz, exp_r, exp_done;
        exp_frz = 3'b110; exp_r = 3'b111; exp_done = 3'b001;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h3);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({freeze, out_mem_r_en, mem_done} !== {exp_frz[2-i], exp_r[2-i], exp_done[2-i]}) begin
                failures++;
                $display("FAIL load_c%0d frz/r/done got=%b%b%b exp=%b%b%b", i + 1,
                         freeze, out_mem_r_en, mem_done, exp_frz[2-i], exp_r[2-i], exp_done[2-i]);
            end
            if (i < 2) tick();
        end
        checks++;
        if (out_alu_result !== 32'h100 || out_dest !== 4'h3) begin
            failures++;
            $display("FAIL load_data alu=%h dest=%h exp=100/3", out_alu_result, out_dest);
        end
        tick();
        checks++;
        if ({out_valid, out_mem_r_en, freeze} !== 3'b000) begin
            failures++;
            $display("FAIL load_after v/r/frz got=%b%b%b exp=000", out_valid, out_mem_r_en, freeze);
        end
`ifdef EXE_MEM_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 32'd2) begin
            failures++;
            $display("FAIL load_stall got=%0d exp=2", stall_cycles);
        end
`endif
    endtask

    task automatic test_store();
        logic [2:0] exp_w, exp_frz;
        exp_w = 3'b001; exp_frz = 3'b110;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'h0);
        tick();
        // a different instruction waiting upstream must not be taken while frozen
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 4'h9);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_mem_w_en, freeze} !== {exp_w[2-i], exp_frz[2-i]}) begin
                failures++;
                $display("FAIL store_c%0d w/frz got=%b%b exp=%b%b", i + 1,
                         out_mem_w_en, freeze, exp_w[2-i], exp_frz[2-i]);
            end
            checks++;
            if (out_alu_result !== 32'h40 || out_st_value !== 32'hDEADBEEF) begin
                failures++;
                $display("FAIL store_hold_c%0d alu=%h st=%h exp=40/deadbeef", i + 1,
                         out_alu_result, out_st_value);
            end
            if (i < 2) tick();
        end
        tick();
        checks++;
        if ({out_valid, out_wb_en, out_mem_w_en, out_alu_result, out_dest} !== {3'b110, 32'h77, 4'h9}) begin
            failures++;
            $display("FAIL store_next v/wb/w=%b%b%b alu=%h dest=%h exp=110/77/9",
                     out_valid, out_wb_en, out_mem_w_en, out_alu_result, out_dest);
        end
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_frz;
        exp_frz = 6'b110110;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 4'h2);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (freeze !== exp_frz[5-i]) begin
                failures++;
                $display("FAIL b2b_freeze_c%0d got=%b exp=%b", i + 1, freeze, exp_frz[5-i]);
            end
            if (i == 2) begin
                checks++;
                if (mem_done !== 1'b1 || out_alu_result !== 32'h100) begin
                    failures++;
                    $display("FAIL b2b_first done=%b alu=%h exp=1/100", mem_done, out_alu_result);
                end
            end
            if (i == 3) begin
                idle();
                checks++;
                if (mem_done !== 1'b0 || out_alu_result !== 32'h200) begin
                    failures++;
                    $display("FAIL b2b_second done=%b alu=%h exp=0/200", mem_done, out_alu_result);
                end
            end
            if (i == 5) begin
                checks++;
                if (mem_done !== 1'b1 || out_dest !== 4'h2) begin
                    failures++;
                    $display("FAIL b2b_second_done done=%b dest=%h exp=1/2", mem_done, out_dest);
                end
            end
            if (i < 5) tick();
        end
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h33, 32'h0, 4'h5);
        flush = 1'b1;
        tick();
        checks++;
        if ({out_valid, out_wb_en, freeze} !== 3'b000 || out_alu_result !== 32'h33) begin
            failures++;
            $display("FAIL flush_idle v/wb/frz=%b%b%b alu=%h exp=000/33",
                     out_valid, out_wb_en, freeze, out_alu_result);
        end
        flush = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h180, 32'h0, 4'h6);
        tick();
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'h7);
        tick();
        tick();
        checks++;
        if ({out_valid, out_mem_r_en, mem_done, freeze} !== 4'b1110 || out_alu_result !== 32'h180) begin
            failures++;
            $display("FAIL flush_wait v/r/done/frz=%b%b%b%b alu=%h exp=1110/180",
                     out_valid, out_mem_r_en, mem_done, freeze, out_alu_result);
        end
        tick();
        checks++;
        if ({out_valid, out_wb_en} !== 2'b00 || out_alu_result !== 32'h55) begin
            failures++;
            $display("FAIL flush_after v/wb=%b%b alu=%h exp=00/55", out_valid, out_wb_en, out_alu_result);
        end
        flush = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_reset_store();
        int w_seen;
        w_seen = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h1234, 4'h0);
        tick();
        idle();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({freeze, out_valid, out_mem_w_en, mem_done} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_store frz/v/w/done=%b%b%b%b exp=0000",
                     freeze, out_valid, out_mem_w_en, mem_done);
        end
`ifdef EXE_MEM_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL rst_stall got=%0d exp=0", stall_cycles);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            if (out_mem_w_en === 1'b1) w_seen++;
            tick();
        end
        checks++;
        if (w_seen !== 0) begin
            failures++;
            $display("FAIL rst_store_no_write w_cycles=%0d exp=0", w_seen);
        end
`ifdef EXE_MEM_STALL_CNT_EN
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h3);
        tick();
        idle();
        tick();
        tick();
        tick();
        checks++;
        if (stall_cycles !== 32'd2) begin
            failures++;
            $display("FAIL rst_load_stall got=%0d exp=2", stall_cycles);
        end
`endif
    endtask

    task automatic test_zero_wait();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h4);
        tick();
        checks++;
        if ({z_freeze, z_mem_r_en, z_mem_done} !== 3'b011 || z_alu_result !== 32'h100) begin
            failures++;
            $display("FAIL zw_load frz/r/done=%b%b%b alu=%h exp=011/100",
                     z_freeze, z_mem_r_en, z_mem_done, z_alu_result);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'hCAFE, 4'h0);
        tick();
        checks++;
        if ({z_freeze, z_mem_w_en, z_mem_r_en, z_mem_done} !== 4'b0111 || z_alu_result !== 32'h40) begin
            failures++;
            $display("FAIL zw_rw frz/w/r/done=%b%b%b%b alu=%h exp=0111/40",
                     z_freeze, z_mem_w_en, z_mem_r_en, z_mem_done, z_alu_result);
        end
        idle();
        tick();
        checks++;
        if ({z_valid, z_mem_w_en, z_freeze} !== 3'b000) begin
            failures++;
            $display("FAIL zw_idle v/w/frz=%b%b%b exp=000", z_valid, z_mem_w_en, z_freeze);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_flush();
        test_reset_store();
        test_zero_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_mem_stage.md
EXE_MEM_STAGE -- requirements
Module: exe_mem_stage

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, extra cycles each load/store occupies the memory stage (0..15).
REQ-002 Parameter DATA_W, default 32, width of ALU result and store value.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  replace the incoming instruction with a bubble.
REQ-006 in_valid, in_wb_en, in_mem_r_en, in_mem_w_en  input  1 each  EXE-stage valid and control bits.
REQ-007 in_alu_result, in_st_value  input  DATA_W each  EXE address/result and store data.
REQ-008 in_dest  input  4  destination register index.
REQ-009 out_valid, out_wb_en, out_mem_r_en, out_mem_w_en  output  1 each  registered controls to the memory stage.
REQ-010 out_alu_result, out_st_value  output  DATA_W each  registered to the memory stage.
REQ-011 out_dest  output  4  registered destination.
REQ-012 freeze  output  1  hold PC, IF/ID and ID/EXE registers this cycle.
REQ-013 mem_done  output  1  memory-stage contents are final; MEM/WB captures only when high.

Function
REQ-014 Capture: when freeze=0, every out_* register loads its in_* counterpart at the clock edge.
REQ-015 Bubble: when freeze=0 and (flush=1 or in_valid=0), out_valid, out_wb_en, out_mem_r_en, out_mem_w_en load 0; data fields load their inputs unchanged.
REQ-016 Hold: when freeze=1, all out_* registers hold; flush and in_* are ignored.
REQ-017 Wait counter cnt (4 bits) loads WAIT_CYCLES when a valid instruction with in_mem_r_en|in_mem_w_en is captured; otherwise decrements by 1 while nonzero and holds at 0.
REQ-018 States: IDLE (cnt=0) and WAIT (cnt>0); IDLE->WAIT on capture of a memory op with WAIT_CYCLES>0; WAIT->IDLE when cnt decrements 1->0.
REQ-019 freeze = (cnt != 0), combinational from the register.
REQ-020 A memory op occupies the memory stage exactly WAIT_CYCLES+1 cycles; a non-memory op occupies 1 cycle.
REQ-021 out_mem_r_en is held high for the whole occupancy of a load.
REQ-022 out_mem_w_en is high only in the final occupancy cycle (cnt=0), so each store writes exactly once.
REQ-023 mem_done = out_valid & (cnt == 0).
REQ-024 Back-to-back memory ops: the second is captured on the edge ending the first's final cycle and reloads cnt; freeze drops for exactly that one cycle.
REQ-025 WAIT_CYCLES=0: freeze is never asserted; the block behaves as a plain pipeline register with bubble insertion.
REQ-026 Instruction with in_mem_r_en and in_mem_w_en both high: treated as a store for REQ-022 and as a load for REQ-021.

Reset
REQ-027 Reset takes priority over flush, freeze and capture.
REQ-028 On reset all out_* registers, cnt and freeze go to 0; mem_done goes to 0.
REQ-029 Reset during WAIT aborts the access: freeze=0 from the next cycle and the pending store is never issued.

Configuration
REQ-030 Macro EXE_MEM_STALL_CNT_EN defined: adds output stall_cycles (32 bits, reset 0) incrementing every cycle freeze=1 and saturating at 0xFFFFFFFF.
REQ-031 Macro undefined: stall_cycles port and counter are absent; all other behaviour is identical.

Structure
REQ-032 Shared pipeline package holds DATA_W, the 4-bit register-index width, and the IDLE/WAIT state encoding.
REQ-033 One sub-module, mem_wait_counter, holds cnt, the state, and freeze/mem_done generation; the data registers stay in the top.

Verification
REQ-034 Reset 1 cycle, then idle -> all outputs 0, freeze=0.
REQ-035 WAIT_CYCLES=2, load alu_result=0x100 -> freeze high 2 cycles; out_mem_r_en high 3 cycles; mem_done high only in 3rd cycle.
REQ-036 WAIT_CYCLES=2, store 0xDEADBEEF to 0x40 -> out_mem_w_en high exactly 1 cycle, in 3rd cycle; upstream held during cycles 1-2.
REQ-037 Two consecutive loads -> freeze pattern 1,1,0,1,1,0; the second load's out_alu_result appears after the first's mem_done.
REQ-038 flush with a valid ADD in IDLE -> next cycle out_valid=0 and out_wb_en=0; flush during WAIT -> ignored, load completes.
REQ-039 Reset asserted in 2nd cycle of a store -> out_mem_w_en never asserted, freeze=0 next cycle; with EXE_MEM_STALL_CNT_EN, stall_cycles reads 0 after reset, 2 after one full load.
